phase_timer: RTL

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/train_ctrl_pkg.sv | 17 +
 rtl/tick_gen.sv | 29 ++
 rtl/phase_timer.sv | 101 ++++++++++
 3 files changed

// File: rtl/train_ctrl_pkg.sv
// Shared controller definitions: phase-timer FSM encoding and controller state codes.
package train_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } timer_state_t;

  localparam logic [3:0] CS_RESET    = 4'b0000;
  localparam logic [3:0] CS_PHASE1   = 4'b0010;
  localparam logic [3:0] CS_PHASE0_A = 4'b0011;
  localparam logic [3:0] CS_PHASE0_B = 4'b0100;
  localparam logic [3:0] CS_PHASE0_C = 4'b0101;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler for phase_timer: counts 0..DIV-1 and flags the wrap cycle.
// Only instantiated when PHASE_TIMER_PRESCALE_EN is defined.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_r;

  assign tick = (count_r == CW'(DIV - 1));

  // Prescale counter, restarted whenever a new duration is being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear || tick) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Phase duration timer: reloads on every controller state change and pulses expired at the end.
// Optional build macro PHASE_TIMER_PRESCALE_EN inserts a tick_gen prescaler of PRESCALE_DIV clocks.
module phase_timer
  import train_ctrl_pkg::*;
#(
  parameter int WIDTH        = 19,
  parameter int STATE_W      = 4,
  parameter int PRESCALE_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   tout,
  input  logic [STATE_W-1:0] present_state,
  output logic               busy,
  output logic               expired,
  output logic [WIDTH-1:0]   remaining
);

  timer_state_t       fsm_r;
  timer_state_t       next_s;
  logic [STATE_W-1:0] state_q;
  logic [WIDTH-1:0]   remaining_r;
  logic [WIDTH-1:0]   remaining_nxt_s;
  logic               busy_r;
  logic               expired_r;
  logic               change_s;
  logic               tick_s;

  assign change_s = (present_state != state_q);

`ifdef PHASE_TIMER_PRESCALE_EN
  tick_gen #(
    .DIV (PRESCALE_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fsm_r == LOAD),
    .tick  (tick_s)
  );
`else
  // PRESCALE_DIV has no effect in this build; every clock is a tick.
  assign tick_s = (PRESCALE_DIV >= 0) || 1'b1;
`endif

  // Next-state selection; a controller state change preempts everything.
  always_comb begin
    next_s = fsm_r;
    if (change_s) begin
      next_s = LOAD;
    end else begin
      case (fsm_r)
        IDLE: next_s = IDLE;
        LOAD: begin
          if (tout == '0) next_s = DONE;
          else            next_s = RUN;
        end
        RUN: begin
          if (tick_s && (remaining_r == WIDTH'(1))) next_s = DONE;
          else                                      next_s = RUN;
        end
        DONE:    next_s = IDLE;
        default: next_s = IDLE;
      endcase
    end
  end

  // Counter update: capture in LOAD, count down in RUN unless preempted, otherwise hold.
  always_comb begin
    remaining_nxt_s = remaining_r;
    case (fsm_r)
      LOAD: remaining_nxt_s = tout;
      RUN: begin
        if (tick_s && !change_s && (remaining_r != '0)) remaining_nxt_s = remaining_r - WIDTH'(1);
        else                                            remaining_nxt_s = remaining_r;
      end
      default: remaining_nxt_s = remaining_r;
    endcase
  end

  // State, counter and output registers; busy/expired track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= IDLE;
      state_q     <= '0;
      remaining_r <= '0;
      busy_r      <= 1'b0;
      expired_r   <= 1'b0;
    end else begin
      fsm_r       <= next_s;
      state_q     <= present_state;
      remaining_r <= remaining_nxt_s;
      busy_r      <= (next_s == LOAD) || (next_s == RUN);
      expired_r   <= (next_s == DONE);
    end
  end

  assign busy      = busy_r;
  assign expired   = expired_r;
  assign remaining = remaining_r;

endmodule
